// File: rtl/axi_common.sv
// Shared AXI4 types: response codes and burst length.
package axi_common;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef logic [7:0] len_t;

endpackage

// File: rtl/axi_error_responder_pkg.sv
// Helpers for the AXI error responder (WLAST consistency check).
package axi_error_responder_pkg;
    import axi_common::*;

    // remaining counts down from AWLEN, so the beat carrying WLAST should see zero
    function automatic logic wlast_mismatch(input logic w_last, input len_t remaining);
        return w_last != (remaining == len_t'(0));
    endfunction

endpackage

// File: rtl/axi_error_read_engine.sv
// R-channel engine of the error responder: accepts one AR, returns ar_len+1 error beats.
module axi_error_read_engine
    import axi_common::*;
#(
    parameter int ID_WIDTH = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ID_WIDTH-1:0] ar_id_i,
    input  len_t                ar_len_i,
    input  logic                ar_valid_i,
    output logic                ar_ready_o,
    output logic [ID_WIDTH-1:0] r_id_o,
    output logic                r_last_o,
    output logic                r_valid_o,
    input  logic                r_ready_i
);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t r_state;
    len_t     beat_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= R_IDLE;
            ar_ready_o <= 1'b1;
            r_valid_o  <= 1'b0;
            r_last_o   <= 1'b0;
            r_id_o     <= '0;
            beat_cnt   <= '0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (ar_valid_i) begin
                        r_id_o     <= ar_id_i;
                        beat_cnt   <= ar_len_i;
                        r_last_o   <= (ar_len_i == len_t'(0));
                        r_valid_o  <= 1'b1;
                        ar_ready_o <= 1'b0;
                        r_state    <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_ready_i) begin
                        if (beat_cnt == len_t'(0)) begin
                            r_valid_o  <= 1'b0;
                            r_last_o   <= 1'b0;
                            ar_ready_o <= 1'b1;
                            r_state    <= R_IDLE;
                        end else begin
                            // r_last is registered, so flag it one beat ahead
                            beat_cnt <= beat_cnt - len_t'(1);
                            r_last_o <= (beat_cnt == len_t'(1));
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_error_responder.sv
// AXI4 default subordinate answering every transaction with ERR_RESP.
// Optional WLAST check and proto_err_o port: define AXI_ERROR_RESPONDER_WLAST_CHECK_EN.
module axi_error_responder
    import axi_common::*;
    import axi_error_responder_pkg::*;
#(
    parameter int                    ID_WIDTH   = 8,
    parameter int                    DATA_WIDTH = 64,
    parameter resp_t                 ERR_RESP   = RESP_DECERR,
    parameter logic [DATA_WIDTH-1:0] RDATA_FILL = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ID_WIDTH-1:0]   aw_id_i,
    input  len_t                  aw_len_i,
    input  logic                  aw_valid_i,
    output logic                  aw_ready_o,
    input  logic                  w_last_i,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    output logic [ID_WIDTH-1:0]   b_id_o,
    output logic [1:0]            b_resp_o,
    output logic                  b_valid_o,
    input  logic                  b_ready_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  len_t                  ar_len_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic                  r_valid_o,
`ifdef AXI_ERROR_RESPONDER_WLAST_CHECK_EN
    output logic                  proto_err_o,
`endif
    input  logic                  r_ready_i
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t w_state;
    logic     w_hs;

    assign w_hs     = w_valid_i && w_ready_o;
    assign b_resp_o = ERR_RESP;
    assign r_resp_o = ERR_RESP;
    assign r_data_o = RDATA_FILL;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state    <= W_IDLE;
            aw_ready_o <= 1'b1;
            w_ready_o  <= 1'b0;
            b_valid_o  <= 1'b0;
            b_id_o     <= '0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (aw_valid_i) begin
                        b_id_o     <= aw_id_i;
                        aw_ready_o <= 1'b0;
                        w_ready_o  <= 1'b1;
                        w_state    <= W_DATA;
                    end
                end
                W_DATA: begin
                    // WLAST alone ends the burst, even when the beat count disagrees
                    if (w_hs && w_last_i) begin
                        w_ready_o <= 1'b0;
                        b_valid_o <= 1'b1;
                        w_state   <= W_RESP;
                    end
                end
                W_RESP: begin
                    if (b_ready_i) begin
                        b_valid_o  <= 1'b0;
                        aw_ready_o <= 1'b1;
                        w_state    <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

`ifdef AXI_ERROR_RESPONDER_WLAST_CHECK_EN
    len_t w_remaining;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_remaining <= '0;
            proto_err_o <= 1'b0;
        end else begin
            proto_err_o <= 1'b0;
            if (w_state == W_IDLE && aw_valid_i) begin
                w_remaining <= aw_len_i;
            end else if (w_hs) begin
                proto_err_o <= wlast_mismatch(w_last_i, w_remaining);
                // hold at zero so beats past AWLEN keep flagging
                if (w_remaining != len_t'(0)) begin
                    w_remaining <= w_remaining - len_t'(1);
                end
            end
        end
    end
`else
    logic unused_aw_len;
    assign unused_aw_len = ^aw_len_i;
`endif

    axi_error_read_engine #(
        .ID_WIDTH (ID_WIDTH)
    ) u_read_engine (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .ar_id_i    (ar_id_i),
        .ar_len_i   (ar_len_i),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .r_id_o     (r_id_o),
        .r_last_o   (r_last_o),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i)
    );

endmodule

// File: tb/tb_axi_error_responder.sv
// Directed bench for axi_error_responder; WLAST check covered when AXI_ERROR_RESPONDER_WLAST_CHECK_EN is defined.
module tb_axi_error_responder;
    import axi_common::*;

    logic        clk;
    logic        rst_ni;
    logic [7:0]  aw_id;
    len_t        aw_len;
    logic        aw_valid;
    logic        aw_ready;
    logic        w_last;
    logic        w_valid;
    logic        w_ready;
    logic [7:0]  b_id;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;
    logic [7:0]  ar_id;
    len_t        ar_len;
    logic        ar_valid;
    logic        ar_ready;
    logic [7:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        r_valid;
    logic        r_ready;
`ifdef AXI_ERROR_RESPONDER_WLAST_CHECK_EN
    logic        proto_err;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    axi_error_responder dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .aw_id_i     (aw_id),
        .aw_len_i    (aw_len),
        .aw_valid_i  (aw_valid),
        .aw_ready_o  (aw_ready),
        .w_last_i    (w_last),
        .w_valid_i   (w_valid),
        .w_ready_o   (w_ready),
        .b_id_o      (b_id),
        .b_resp_o    (b_resp),
        .b_valid_o   (b_valid),
        .b_ready_i   (b_ready),
        .ar_id_i     (ar_id),
        .ar_len_i    (ar_len),
        .ar_valid_i  (ar_valid),
        .ar_ready_o  (ar_ready),
        .r_id_o      (r_id),
        .r_data_o    (r_data),
        .r_resp_o    (r_resp),
        .r_last_o    (r_last),
        .r_valid_o   (r_valid),
`ifdef AXI_ERROR_RESPONDER_WLAST_CHECK_EN
        .proto_err_o (proto_err),
`endif
        .r_ready_i   (r_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    int beats, last_bad, stall_bad, w_leak;
    logic prev_stall, prev_last;

    initial begin
        rst_ni = 1'b0;
        aw_id = '0; aw_len = '0; aw_valid = 1'b0;
        w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
        ar_id = '0; ar_len = '0; ar_valid = 1'b0; r_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        chk("rst_aw_ready", aw_ready, 1);
        chk("rst_ar_ready", ar_ready, 1);
        chk("rst_w_ready", w_ready, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_r_valid", r_valid, 0);
        chk("rst_r_last", r_last, 0);
        chk("rst_b_id", b_id, 0);
        chk("rst_r_id", r_id, 0);
`ifdef AXI_ERROR_RESPONDER_WLAST_CHECK_EN
        chk("rst_proto_err", proto_err, 0);
`endif
        rst_ni = 1'b1;
        step();

        // write burst: id 3, 4 beats
        aw_id = 8'h3; aw_len = 8'd3; aw_valid = 1'b1; b_ready = 1'b1;
        step();
        aw_valid = 1'b0;
        chk("wr_w_ready", w_ready, 1);
        chk("wr_aw_ready_busy", aw_ready, 0);
        for (int i = 0; i < 4; i++) begin
            chk("wr_no_b_early", b_valid, 0);
            w_valid = 1'b1;
            w_last  = (i == 3);
            step();
        end
        w_valid = 1'b0; w_last = 1'b0;
        chk("wr_b_valid", b_valid, 1);
        chk("wr_b_id", b_id, 8'h3);
        chk("wr_b_resp", b_resp, 2'b11);
        chk("wr_w_ready_done", w_ready, 0);
`ifdef AXI_ERROR_RESPONDER_WLAST_CHECK_EN
        chk("wr_no_proto_err", proto_err, 0);
`endif
        step();
        chk("wr_b_cleared", b_valid, 0);
        chk("wr_aw_ready_back", aw_ready, 1);

        // single-beat read
        ar_id = 8'h5; ar_len = 8'd0; ar_valid = 1'b1; r_ready = 1'b1;
        step();
        ar_valid = 1'b0;
        chk("rd1_r_valid", r_valid, 1);
        chk("rd1_r_last", r_last, 1);
        chk("rd1_r_resp", r_resp, 2'b11);
        chk("rd1_r_data", r_data, 64'h0);
        chk("rd1_r_id", r_id, 8'h5);
        chk("rd1_ar_busy", ar_ready, 0);
        step();
        chk("rd1_r_done", r_valid, 0);
        chk("rd1_ar_back", ar_ready, 1);

        // 256-beat read with r_ready toggling
        ar_id = 8'h7; ar_len = 8'd255; ar_valid = 1'b1; r_ready = 1'b0;
        step();
        ar_valid = 1'b0;
        beats = 0; last_bad = 0; stall_bad = 0;
        prev_stall = 1'b0; prev_last = 1'b0;
        for (int cyc = 0; cyc < 1200 && beats < 256; cyc++) begin
            r_ready = cyc[0];
            if (prev_stall && (r_valid !== 1'b1 || r_id !== 8'h7 || r_last !== prev_last))
                stall_bad++;
            if (r_valid && r_ready) begin
                if (r_last !== (beats == 255)) last_bad++;
                beats++;
            end
            prev_stall = r_valid && !r_ready;
            prev_last  = r_last;
            step();
        end
        r_ready = 1'b0;
        chk("rd256_beats", beats, 256);
        chk("rd256_last_pos", last_bad, 0);
        chk("rd256_stable", stall_bad, 0);
        chk("rd256_r_done", r_valid, 0);
        chk("rd256_ar_back", ar_ready, 1);

        // W before AW, concurrent 2-beat read
        w_valid = 1'b1; w_last = 1'b1; w_leak = 0;
        for (int i = 0; i < 5; i++) begin
            if (w_ready !== 1'b0 || b_valid !== 1'b0) w_leak++;
            step();
        end
        chk("early_w_stalled", w_leak, 0);
        aw_id = 8'hA; aw_len = 8'd0; aw_valid = 1'b1;
        ar_id = 8'h2; ar_len = 8'd1; ar_valid = 1'b1;
        r_ready = 1'b1; b_ready = 1'b1;
        step();
        aw_valid = 1'b0; ar_valid = 1'b0;
        chk("mix_w_ready", w_ready, 1);
        chk("mix_r_valid", r_valid, 1);
        chk("mix_r_last0", r_last, 0);
        step();
        w_valid = 1'b0; w_last = 1'b0;
        chk("mix_b_valid", b_valid, 1);
        chk("mix_b_id", b_id, 8'hA);
        chk("mix_r_last1", r_last, 1);
        chk("mix_r_id", r_id, 8'h2);
        step();
        chk("mix_b_done", b_valid, 0);
        chk("mix_r_done", r_valid, 0);
        chk("mix_aw_back", aw_ready, 1);
        chk("mix_ar_back", ar_ready, 1);

        // reset mid read burst
        ar_id = 8'h9; ar_len = 8'd7; ar_valid = 1'b1; r_ready = 1'b1;
        step();
        ar_valid = 1'b0;
        step();
        step();
        chk("mid_r_valid_pre", r_valid, 1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_r_valid", r_valid, 0);
        chk("mid_rst_ar_ready", ar_ready, 1);
        chk("mid_rst_r_last", r_last, 0);
        r_ready = 1'b0;
        step();
        rst_ni = 1'b1;
        step();
        ar_id = 8'h4; ar_len = 8'd1; ar_valid = 1'b1;
        step();
        ar_valid = 1'b0;
        chk("post_rst_r_valid", r_valid, 1);
        chk("post_rst_r_id", r_id, 8'h4);
        chk("post_rst_r_last0", r_last, 0);
        r_ready = 1'b1;
        step();
        chk("post_rst_r_last1", r_last, 1);
        step();
        chk("post_rst_r_done", r_valid, 0);
        r_ready = 1'b0;

`ifdef AXI_ERROR_RESPONDER_WLAST_CHECK_EN
        // early WLAST on beat 2 of 4
        aw_id = 8'h6; aw_len = 8'd3; aw_valid = 1'b1; b_ready = 1'b0;
        step();
        aw_valid = 1'b0;
        w_valid = 1'b1; w_last = 1'b0;
        step();
        chk("pe_beat1_ok", proto_err, 0);
        w_last = 1'b1;
        step();
        w_valid = 1'b0; w_last = 1'b0;
        chk("pe_pulse", proto_err, 1);
        chk("pe_b_valid", b_valid, 1);
        chk("pe_b_id", b_id, 8'h6);
        step();
        chk("pe_pulse_end", proto_err, 0);
        b_ready = 1'b1;
        step();
        chk("pe_b_done", b_valid, 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
